// File: rtl/bcdup.sv
// bcdup: two-digit BCD up counter (00..99) for the score / shot display.
//
// Supports a +1 step, a single-digit BCD addition and a synchronous load.
// Only one operation runs per edge: reset > load > add > step.
//
// Parameters
//   WRAP    0: saturate at 99 on overflow, 1: wrap modulo 100
//   INIT_L  low digit after reset (0..9)
//   INIT_H  high digit after reset (0..9)
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   loadN    synchronous load, active-low (datainL/datainH, clamped to 9)
//   enable1  step qualifier; a step needs enable1 && enable2
//   enable2  step qualifier
//   add_req  one-cycle request to add add_val
//   add_val  BCD digit to add; values above 9 make the request a no-op
//   datainL  load value, low digit
//   datainH  load value, high digit
//   countL   low BCD digit, registered
//   countH   high BCD digit, registered
//   tc       combinational, high when the count is 99
//   ovf      registered sticky overflow, cleared only by reset or load
module bcdup #(
    parameter bit          WRAP   = 1'b0,
    parameter int unsigned INIT_L = 0,
    parameter int unsigned INIT_H = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadN,
    input  logic       enable1,
    input  logic       enable2,
    input  logic       add_req,
    input  logic [3:0] add_val,
    input  logic [3:0] datainL,
    input  logic [3:0] datainH,
    output logic [3:0] countL,
    output logic [3:0] countH,
    output logic       tc,
    output logic       ovf
);

    logic [4:0] sum_l;   // countL + add_val, 0..18
    logic [3:0] add_l;   // low digit after the add
    logic       carry;
    logic [3:0] add_h;   // countH + carry, 0..10 (10 means overflow)

    always_comb begin
        sum_l = {1'b0, countL} + {1'b0, add_val};
        if (sum_l > 5'd9) begin
            add_l = 4'(sum_l - 5'd10);
            carry = 1'b1;
        end else begin
            add_l = sum_l[3:0];
            carry = 1'b0;
        end
        add_h = countH + {3'b000, carry};
    end

    assign tc = (countH == 4'd9) && (countL == 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            countL <= 4'(INIT_L);
            countH <= 4'(INIT_H);
            ovf    <= 1'b0;
        end else if (!loadN) begin
            countL <= (datainL > 4'd9) ? 4'd9 : datainL;
            countH <= (datainH > 4'd9) ? 4'd9 : datainH;
            ovf    <= 1'b0;
        end else if (add_req) begin
            // An illegal add_val still claims the edge, so a concurrent step is dropped.
            if (add_val <= 4'd9) begin
                if (add_h == 4'd10) begin
                    ovf <= 1'b1;
                    if (WRAP) begin
                        countL <= add_l;
                        countH <= '0;
                    end else begin
                        countL <= 4'd9;
                        countH <= 4'd9;
                    end
                end else begin
                    countL <= add_l;
                    countH <= add_h;
                end
            end
        end else if (enable1 && enable2) begin
            if (countL == 4'd9) begin
                if (countH == 4'd9) begin
                    ovf <= 1'b1;
                    if (WRAP) begin
                        countL <= '0;
                        countH <= '0;
                    end
                end else begin
                    countL <= '0;
                    countH <= countH + 4'd1;
                end
            end else begin
                countL <= countL + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bcdup.sv
module tb_bcdup;

    logic       clk = 1'b0;
    logic       reset, loadN, enable1, enable2, add_req;
    logic [3:0] add_val, datainL, datainH;

    logic [3:0] cl0, ch0, cl1, ch1;
    logic       tc0, tc1, ovf0, ovf1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Saturating instance, reset to 00.
    bcdup #(.WRAP(1'b0), .INIT_L(0), .INIT_H(0)) dut0 (
        .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .add_req(add_req), .add_val(add_val), .datainL(datainL), .datainH(datainH),
        .countL(cl0), .countH(ch0), .tc(tc0), .ovf(ovf0)
    );

    // Wrapping instance, reset to 72.
    bcdup #(.WRAP(1'b1), .INIT_L(2), .INIT_H(7)) dut1 (
        .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .add_req(add_req), .add_val(add_val), .datainL(datainL), .datainH(datainH),
        .countL(cl1), .countH(ch1), .tc(tc1), .ovf(ovf1)
    );

    typedef struct {
        logic       rst;
        logic       ldn;
        logic       e1;
        logic       e2;
        logic       ar;
        logic [3:0] av;
        logic [3:0] dl;
        logic [3:0] dh;
        logic [7:0] exp0;   // BCD {H,L} expected on the saturating instance
        logic       ovf0;
        logic [7:0] exp1;   // BCD {H,L} expected on the wrapping instance
        logic       ovf1;
    } vec_t;

    typedef struct {
        int v;
        bit o;
    } mstate_t;

    // Reference: the count as a plain integer 0..99.
    function automatic mstate_t mnext(mstate_t s, bit wrap, int init, logic rst, logic ldn,
                                      logic e1, logic e2, logic ar, logic [3:0] av,
                                      logic [3:0] dl, logic [3:0] dh);
        mstate_t n = s;
        int t;
        if (rst) begin
            n.v = init;
            n.o = 1'b0;
        end else if (!ldn) begin
            n.v = ((dh > 4'd9) ? 9 : int'(dh)) * 10 + ((dl > 4'd9) ? 9 : int'(dl));
            n.o = 1'b0;
        end else if (ar) begin
            if (av <= 4'd9) begin
                t = s.v + int'(av);
                if (t > 99) begin
                    n.o = 1'b1;
                    n.v = wrap ? t - 100 : 99;
                end else begin
                    n.v = t;
                end
            end
        end else if (e1 && e2) begin
            t = s.v + 1;
            if (t > 99) begin
                n.o = 1'b1;
                n.v = wrap ? 0 : 99;
            end else begin
                n.v = t;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check8(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check1(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic drive(logic rst, logic ldn, logic e1, logic e2, logic ar,
                         logic [3:0] av, logic [3:0] dl, logic [3:0] dh);
        reset   = rst;
        loadN   = ldn;
        enable1 = e1;
        enable2 = e2;
        add_req = ar;
        add_val = av;
        datainL = dl;
        datainH = dh;
    endtask

    vec_t    tbl[$];
    mstate_t m0, m1;

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

        //            rst  ldn  e1   e2   ar   av     dl     dh     exp0   o0    exp1   o1
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,4'd0, 4'd0, 4'd0, 8'h00,1'b0,8'h72,1'b0}); // reset
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd7, 4'd4, 8'h47,1'b0,8'h47,1'b0}); // load 47
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h48,1'b0,8'h48,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h49,1'b0,8'h49,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h50,1'b0,8'h50,1'b0}); // low carry
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd5, 4'd9, 8'h95,1'b0,8'h95,1'b0}); // load 95
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,4'd7, 4'd0, 4'd0, 8'h99,1'b1,8'h02,1'b1}); // add overflow
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd8, 4'd9, 8'h98,1'b0,8'h98,1'b0}); // load clears ovf
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h99,1'b0,8'h99,1'b0}); // reach 99
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h99,1'b1,8'h00,1'b1}); // step overflow
        tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1,4'd5, 4'd2, 4'd1, 8'h12,1'b0,8'h12,1'b0}); // load wins
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd8, 4'd0, 8'h08,1'b0,8'h08,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,4'd5, 4'd0, 4'd0, 8'h13,1'b0,8'h13,1'b0}); // add beats step
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,4'd12,4'd0, 4'd0, 8'h13,1'b0,8'h13,1'b0}); // illegal add
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,4'd0, 4'd0, 4'd0, 8'h13,1'b0,8'h13,1'b0}); // add zero
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd15,4'd12,8'h99,1'b0,8'h99,1'b0}); // load clamp
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 4'd0, 4'd0, 8'h99,1'b0,8'h99,1'b0}); // idle
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 4'd3, 4'd3, 8'h33,1'b0,8'h33,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,4'd0, 4'd0, 4'd0, 8'h33,1'b0,8'h33,1'b0}); // one enable
        tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,4'd0, 4'd0, 4'd0, 8'h33,1'b0,8'h33,1'b0}); // other enable
        tbl.push_back('{1'b1,1'b0,1'b1,1'b1,1'b1,4'd4, 4'd1, 4'd1, 8'h00,1'b0,8'h72,1'b0}); // reset wins

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ldn, tbl[i].e1, tbl[i].e2, tbl[i].ar,
                  tbl[i].av, tbl[i].dl, tbl[i].dh);
            @(posedge clk);
            #1;
            check8($sformatf("vec%0d_count_sat", i), {ch0, cl0}, tbl[i].exp0);
            check1($sformatf("vec%0d_ovf_sat", i), ovf0, tbl[i].ovf0);
            check1($sformatf("vec%0d_tc_sat", i), tc0, tbl[i].exp0 == 8'h99);
            check8($sformatf("vec%0d_count_wrap", i), {ch1, cl1}, tbl[i].exp1);
            check1($sformatf("vec%0d_ovf_wrap", i), ovf1, tbl[i].ovf1);
            check1($sformatf("vec%0d_tc_wrap", i), tc1, tbl[i].exp1 == 8'h99);
        end

        // Randomized run against the integer reference; first cycle is a reset to sync the model.
        m0 = '{0, 1'b0};
        m1 = '{0, 1'b0};
        for (int c = 0; c < 3000; c++) begin
            logic rst, ldn, e1, e2, ar;
            logic [3:0] av, dl, dh;
            rst = (c == 0) || ($urandom_range(0, 59) == 0);
            ldn = ($urandom_range(0, 11) != 0);
            e1  = ($urandom_range(0, 3) != 0);
            e2  = ($urandom_range(0, 3) != 0);
            ar  = ($urandom_range(0, 3) == 0);
            av  = 4'($urandom_range(0, 15));
            dl  = 4'($urandom_range(0, 15));
            dh  = 4'($urandom_range(0, 15));
            m0 = mnext(m0, 1'b0, 0,  rst, ldn, e1, e2, ar, av, dl, dh);
            m1 = mnext(m1, 1'b1, 72, rst, ldn, e1, e2, ar, av, dl, dh);
            drive(rst, ldn, e1, e2, ar, av, dl, dh);
            @(posedge clk);
            #1;
            check8($sformatf("rnd%0d_count_sat", c), {ch0, cl0}, to_bcd(m0.v));
            check1($sformatf("rnd%0d_ovf_sat", c), ovf0, m0.o);
            check1($sformatf("rnd%0d_tc_sat", c), tc0, m0.v == 99);
            check8($sformatf("rnd%0d_count_wrap", c), {ch1, cl1}, to_bcd(m1.v));
            check1($sformatf("rnd%0d_ovf_wrap", c), ovf1, m1.o);
            check1($sformatf("rnd%0d_tc_wrap", c), tc1, m1.v == 99);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
